pc_unit: RTL and testbench

//  Parametrised program-counter unit for the pipelined datapath; supersedes the bare PC register.

---
 rtl/pc_unit.sv | 116 +++++++++++
 tb/tb_pc_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC, sequential next PC, trap/mret/branch redirect, stall, halt/resume, EPC.
// Latency: requests sampled at the falling clk edge, visible on pc_out right after that edge.
// Backpressure: stall holds the PC unless a redirect is present; HALT holds it until resume or trap.
//
// Ports:
//   clk, rst              falling-edge clock, asynchronous active-low reset
//   stall, br_taken,      hazard hold, branch redirect request and its target,
//   br_target, trap_req,  exception/interrupt request, return-from-trap,
//   mret, halt_req,       enter HALT after this update,
//   resume                leave HALT
//   pc_out, pc_next       registered fetch PC and the value it takes at the next edge
//   pc_valid              pc_out is fetchable (RUN only)
//   epc_out               PC saved on the last accepted trap
//   misaligned            one-cycle pulse after a taken branch whose target had low bits set
module pc_unit #(
    parameter int              XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              INSTR_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_req,
    input  logic            mret,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc_out,
    output logic            misaligned
);

    // Low address bits that must be zero for an instruction-aligned PC.
    localparam logic [XLEN-1:0] LOW_BITS = XLEN'(INSTR_BYTES - 1);
    localparam logic [XLEN-1:0] INC      = XLEN'(INSTR_BYTES);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t          state_q, state_nxt;
    logic [XLEN-1:0] pc_q, pc_nxt;
    logic [XLEN-1:0] epc_q, epc_nxt;
    logic            mis_q, mis_nxt;

    // Datapath convention: all state moves on the falling edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            epc_q   <= epc_nxt;
            mis_q   <= mis_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        epc_nxt   = epc_q;
        mis_nxt   = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // Redirects beat stall: the instruction they flush never needs the held PC.
                // Lower-priority requests arriving with a higher one are dropped.
                if (trap_req) begin
                    pc_nxt  = TRAP_VECTOR;
                    epc_nxt = pc_q;
                end else if (mret) begin
                    pc_nxt = epc_q;
                end else if (br_taken) begin
                    pc_nxt  = br_target & ~LOW_BITS;
                    mis_nxt = |(br_target & LOW_BITS);
                end else if (!stall) begin
                    pc_nxt = pc_q + INC;  // wraps modulo 2^XLEN
                end
                // The update selected above still lands on the edge that enters HALT.
                if (halt_req) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                if (trap_req) begin
                    pc_nxt    = TRAP_VECTOR;
                    epc_nxt   = pc_q;
                    state_nxt = S_RUN;
                end else if (resume) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    assign pc_out     = pc_q;
    assign pc_next    = pc_nxt;
    assign pc_valid   = (state_q == S_RUN);
    assign epc_out    = epc_q;
    assign misaligned = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int          XLEN = 64;
    localparam int          IB   = 4;
    localparam logic [63:0] RV   = 64'h0;
    localparam logic [63:0] TV   = 64'h100;

    logic            clk;
    logic            rst;
    logic            stall, br_taken, trap_req, mret, halt_req, resume;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] pc_out, pc_next, epc_out;
    logic            pc_valid, misaligned;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural view (PC, EPC, whether booting or halted).
    logic [63:0] m_pc, m_epc;
    logic        m_mis, m_boot, m_halt;

    pc_unit #(
        .XLEN        (XLEN),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR (TV),
        .INSTR_BYTES (IB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .trap_req  (trap_req),
        .mret      (mret),
        .halt_req  (halt_req),
        .resume    (resume),
        .pc_out    (pc_out),
        .pc_next   (pc_next),
        .pc_valid  (pc_valid),
        .epc_out   (epc_out),
        .misaligned(misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = RV;
        m_epc  = '0;
        m_mis  = 1'b0;
        m_boot = 1'b1;
        m_halt = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pc"},    pc_out, m_pc);
        chk({tag, ".epc"},   epc_out, m_epc);
        chk({tag, ".valid"}, {63'b0, pc_valid}, {63'b0, !m_boot && !m_halt});
        chk({tag, ".mis"},   {63'b0, misaligned}, {63'b0, m_mis});
    endtask

    task automatic drive(input logic s, input logic b, input logic [63:0] t,
                         input logic tr, input logic mr, input logic h, input logic r);
        stall = s; br_taken = b; br_target = t; trap_req = tr;
        mret = mr; halt_req = h; resume = r;
    endtask

    // Called right after a rising edge with inputs already driven: checks pc_next,
    // advances through one falling edge, then checks registered outputs.
    task automatic cycle(input string tag);
        logic [63:0] n_pc, n_epc;
        logic        n_mis, n_boot, n_halt;
        n_pc = m_pc; n_epc = m_epc; n_mis = 1'b0; n_boot = 1'b0; n_halt = m_halt;
        if (m_boot) begin
            // boot cycle: nothing moves but the mode
        end else if (m_halt) begin
            if (trap_req) begin
                n_epc = m_pc; n_pc = TV; n_halt = 1'b0;
            end else if (resume) begin
                n_halt = 1'b0;
            end
        end else begin
            if (trap_req) begin
                n_epc = m_pc; n_pc = TV;
            end else if (mret) begin
                n_pc = m_epc;
            end else if (br_taken) begin
                n_pc  = br_target - (br_target % IB);
                n_mis = (br_target % IB) != 0;
            end else if (!stall) begin
                n_pc = m_pc + IB;
            end
            if (halt_req) n_halt = 1'b1;
        end
        #1;
        chk({tag, ".pc_next"}, pc_next, n_pc);
        @(negedge clk);
        m_pc = n_pc; m_epc = n_epc; m_mis = n_mis; m_boot = n_boot; m_halt = n_halt;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle_cycle(input string tag);
        drive(0, 0, 64'h0, 0, 0, 0, 0);
        cycle(tag);
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        drive(0, 0, 64'h0, 0, 0, 0, 0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 0, 64'h0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        @(posedge clk);
        rst = 1'b1;
        #1;
        check_outputs("boot");

        // BOOT then sequential fetch 0,4,8,C,10
        for (int i = 0; i < 5; i++) idle_cycle("seq");
        chk("seq_end", pc_out, 64'h10);

        // stall holds, redirect overrides stall
        drive(1, 0, 64'h0, 0, 0, 0, 0); cycle("stall1");
        drive(1, 0, 64'h0, 0, 0, 0, 0); cycle("stall2");
        chk("stall_hold", pc_out, 64'h10);
        drive(1, 1, 64'h40, 0, 0, 0, 0); cycle("stall_br");
        chk("stall_br_pc", pc_out, 64'h40);

        // misaligned target: aligned down, one-cycle pulse
        drive(0, 1, 64'h43, 0, 0, 0, 0); cycle("mis_br");
        chk("mis_pulse", {63'b0, misaligned}, 64'h1);
        idle_cycle("mis_after");
        chk("mis_clear", {63'b0, misaligned}, 64'h0);

        // trap beats branch, then mret returns to EPC
        drive(0, 1, 64'h20, 0, 0, 0, 0); cycle("to20");
        drive(0, 1, 64'h80, 1, 0, 0, 0); cycle("trap_br");
        chk("trap_pc", pc_out, 64'h100);
        chk("trap_epc", epc_out, 64'h20);
        idle_cycle("in_handler");
        drive(0, 0, 64'h0, 0, 1, 0, 0); cycle("mret");
        chk("mret_pc", pc_out, 64'h20);

        // wrap at top of address space
        drive(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0); cycle("to_top");
        idle_cycle("wrap");
        chk("wrap_pc", pc_out, 64'h0);

        // halt at 0x8, held, resume, then rst mid-HALT
        idle_cycle("h4");
        idle_cycle("h8");
        drive(0, 0, 64'h0, 0, 0, 1, 0); cycle("halt");
        chk("halt_pc", pc_out, 64'hC);
        for (int i = 0; i < 5; i++) idle_cycle("halted");
        drive(0, 0, 64'h0, 0, 0, 0, 1); cycle("resume");
        idle_cycle("post_resume");
        chk("resume_pc", pc_out, 64'h10);
        drive(0, 0, 64'h0, 0, 0, 1, 0); cycle("halt2");
        idle_cycle("halted2");
        mid_reset("rst_in_halt");

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [63:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                              : 64'($urandom_range(0, 1023));
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, tgt,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
            cycle("rand");
            if ($urandom_range(0, 99) == 0) mid_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
